// File: rtl/spi_master_if.sv
// Host-bus strobes and SPI pins of spi_master. The block is a slave on the host bus,
// so it uses the "slave" modport; the host/bench side uses "master".
interface spi_master_if;
   logic       CS;
   logic [1:0] addr;
   logic       WR;
   logic       RD;
   logic       miso;
   logic       mosi;
   logic       sclk;
   logic [7:0] ss;

   modport slave  (input  CS, addr, WR, RD, miso, output mosi, sclk, ss);
   modport master (output CS, addr, WR, RD, miso, input  mosi, sclk, ss);
endinterface

// File: rtl/spi_master.sv
// Host-bus mapped SPI master: CTRL/STATUS/TXBUF/RXBUF registers, one 8-bit MSB-first
// full-duplex transfer per TXBUF write, all four CPOL/CPHA modes, sclk = pro_clk/2^(DIV+1).
module spi_master (
   input  logic        pro_clk,
   input  logic        rst,
   inout  wire  [7:0]  data_bus,
   spi_master_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ASSERT, SHIFT, RELEASE} state_t;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_TXBUF  = 2'd2;
   localparam logic [1:0] A_RXBUF  = 2'd3;

   state_t     state, state_nxt;
   logic [7:0] ctrl, txbuf, rxbuf, tx_sh, rx_sh, ss_q, rd_data;
   logic [6:0] cnt;
   logic [4:0] edge_cnt;
   logic       sclk_q, mosi_q, done, busy;
   logic       wr_en, rd_en, tick, leading, drive, sample;
   logic       start, do_edge, do_release;

   function automatic logic [6:0] half_last(input logic [2:0] div);
      half_last = 7'((8'd1 << div) - 8'd1);
   endfunction

   // CTRL cannot change while busy, so it doubles as the per-transfer configuration.
   assign busy    = (state != IDLE);
   assign wr_en   = bus.CS & bus.WR;
   assign rd_en   = bus.CS & bus.RD;
   assign tick    = (cnt == half_last(ctrl[2:0]));
   assign leading = ~edge_cnt[0];
   assign drive   = ctrl[4] ? leading : (~leading & (edge_cnt != 5'd15));
   assign sample  = ctrl[4] ? ~leading : leading;

   always_comb begin
      state_nxt  = state;
      start      = 1'b0;
      do_edge    = 1'b0;
      do_release = 1'b0;
      case (state)
         IDLE: begin
            if (wr_en && bus.addr == A_TXBUF) begin
               start     = 1'b1;
               state_nxt = ASSERT;
            end
         end
         ASSERT: state_nxt = SHIFT;
         SHIFT: begin
            if (tick) begin
               do_edge = 1'b1;
               if (edge_cnt == 5'd15) state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            if (tick) begin
               do_release = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_data = 8'h00;
      case (bus.addr)
         A_CTRL:   rd_data = ctrl;
         A_STATUS: rd_data = {6'b0, busy, done};
         A_TXBUF:  rd_data = txbuf;
         A_RXBUF:  rd_data = rxbuf;
         default:  rd_data = 8'h00;
      endcase
   end

   assign data_bus = rd_en ? rd_data : 8'bz;

   always_ff @(posedge pro_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge pro_clk or posedge rst) begin
      if (rst) begin
         ctrl     <= 8'h00;
         txbuf    <= 8'h00;
         rxbuf    <= 8'h00;
         tx_sh    <= 8'h00;
         rx_sh    <= 8'h00;
         done     <= 1'b0;
         cnt      <= 7'd0;
         edge_cnt <= 5'd0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         ss_q     <= 8'hFF;
      end else begin
         if (wr_en && bus.addr == A_CTRL && !busy) ctrl <= data_bus;
         if (rd_en && bus.addr == A_RXBUF) done <= 1'b0;
         if (start) begin
            txbuf <= data_bus;
            tx_sh <= data_bus;
            done  <= 1'b0;
         end
         if (state == IDLE) sclk_q <= ctrl[3];

         case (state)
            ASSERT: begin
               ss_q     <= ~(8'd1 << ctrl[7:5]);
               cnt      <= 7'd0;
               edge_cnt <= 5'd0;
               // CPHA=0 presents bit7 together with the ss fall.
               if (!ctrl[4]) begin
                  mosi_q <= tx_sh[7];
                  tx_sh  <= {tx_sh[6:0], 1'b0};
               end
            end
            SHIFT, RELEASE: cnt <= tick ? 7'd0 : cnt + 7'd1;
            default: ;
         endcase

         if (do_edge) begin
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + 5'd1;
            if (drive) begin
               mosi_q <= tx_sh[7];
               tx_sh  <= {tx_sh[6:0], 1'b0};
            end
            if (sample) rx_sh <= {rx_sh[6:0], bus.miso};
         end

         if (do_release) begin
            ss_q  <= 8'hFF;
            rxbuf <= rx_sh;
            done  <= 1'b1;
         end
      end
   end

   assign bus.mosi = mosi_q;
   assign bus.sclk = sclk_q;
   assign bus.ss   = ss_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: host-bus tasks plus a mode-aware SPI slave model
// that returns a known byte and captures mosi on the mode's sampling edges.
module tb_spi_master;
   logic       pro_clk = 1'b0;
   logic       rst = 1'b1;
   wire  [7:0] data_bus;
   logic       drv_en = 1'b0;
   logic [7:0] drv_val = 8'h00;
   int         checks = 0;
   int         errors = 0;

   spi_master_if bus();

   assign data_bus = drv_en ? drv_val : 8'bz;

   spi_master dut (.pro_clk(pro_clk), .rst(rst), .data_bus(data_bus), .bus(bus));

   always #5 pro_clk = ~pro_clk;

   logic       m_cpol = 1'b0, m_cpha = 1'b0;
   logic [7:0] slv_tx = 8'h00, mon_mosi = 8'h00, mon_sel = 8'hFF, prev_ss = 8'hFF;
   logic       prev_sclk = 1'b0, mon_idle_sclk = 1'b0;
   int         m_h = 1, mon_low = 0, mon_edges = 0, mon_gap = 0, mon_gap_err = 0;
   int         mon_multi = 0, bit_i = 0;

   // Slave model: observes the bus between clock edges and launches miso one edge ahead.
   always @(negedge pro_clk) begin
      if (rst) begin
         prev_ss   = 8'hFF;
         prev_sclk = 1'b0;
         bus.miso  = 1'b0;
      end else begin
         if (bus.ss != 8'hFF) begin
            if (prev_ss == 8'hFF) begin
               mon_low = 1; mon_edges = 0; mon_gap = 0; mon_gap_err = 0;
               mon_multi = 0; mon_mosi = 8'h00; bit_i = 0;
               mon_sel = bus.ss; mon_idle_sclk = bus.sclk;
               if (!m_cpha) begin
                  bus.miso = slv_tx[7];
                  bit_i = 1;
               end
            end else begin
               mon_low++;
               mon_gap++;
               if (bus.sclk != prev_sclk) begin
                  mon_edges++;
                  if (mon_gap != m_h) mon_gap_err++;
                  mon_gap = 0;
                  if ((bus.sclk != m_cpol) ^ m_cpha) mon_mosi = {mon_mosi[6:0], bus.mosi};
                  else if (bit_i < 8) begin
                     bus.miso = slv_tx[3'(7 - bit_i)];
                     bit_i++;
                  end
               end
            end
            if ($countones(~bus.ss) != 1) mon_multi++;
         end
         prev_ss   = bus.ss;
         prev_sclk = bus.sclk;
      end
   end

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge pro_clk);
      bus.CS = 1'b1; bus.WR = 1'b1; bus.addr = a; drv_val = d; drv_en = 1'b1;
      @(posedge pro_clk);
      #1;
      bus.CS = 1'b0; bus.WR = 1'b0; drv_en = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge pro_clk);
      bus.CS = 1'b1; bus.RD = 1'b1; bus.addr = a;
      #1;
      d = data_bus;
      @(posedge pro_clk);
      #1;
      bus.CS = 1'b0; bus.RD = 1'b0;
   endtask

   task automatic wait_idle();
      logic [7:0] st;
      int n;
      n = 0;
      bus_read(2'd1, st);
      while (st[1] && n < 2000) begin
         bus_read(2'd1, st);
         n++;
      end
      checks++;
      if (st[1]) begin
         errors++;
         $display("FAIL busy_timeout status=%h want busy=0 within 2000 polls", st);
      end
   endtask

   task automatic set_model(input logic [7:0] c, input logic [7:0] resp);
      m_cpol = c[3];
      m_cpha = c[4];
      m_h    = 1 << c[2:0];
      slv_tx = resp;
   endtask

   task automatic run_xfer(input logic [7:0] c, input logic [7:0] tx, input logic [7:0] resp);
      set_model(c, resp);
      bus_write(2'd0, c);
      bus_write(2'd2, tx);
      wait_idle();
   endtask

   task automatic test_reset();
      logic [7:0] d;
      checks++; if (bus.ss !== 8'hFF) begin errors++; $display("FAIL rst_ss got %h want FF", bus.ss); end
      checks++; if (bus.sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b want 0", bus.sclk); end
      checks++; if (bus.mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", bus.mosi); end
      for (int a = 0; a < 4; a++) begin
         bus_read(2'(a), d);
         checks++;
         if (d !== 8'h00) begin errors++; $display("FAIL rst_reg%0d got %h want 00", a, d); end
      end
   endtask

   task automatic test_mode0();
      logic [7:0] d;
      run_xfer(8'h00, 8'hA5, 8'h3C);
      checks++; if (mon_low !== 17) begin errors++; $display("FAIL m0_ss_low got %0d want 17", mon_low); end
      checks++; if (mon_sel !== 8'hFE) begin errors++; $display("FAIL m0_sel got %h want FE", mon_sel); end
      checks++; if (mon_idle_sclk !== 1'b0) begin errors++; $display("FAIL m0_idle got %b want 0", mon_idle_sclk); end
      checks++; if (mon_edges !== 16) begin errors++; $display("FAIL m0_edges got %0d want 16", mon_edges); end
      checks++; if (mon_gap_err !== 0) begin errors++; $display("FAIL m0_halfper got %0d bad gaps want 0", mon_gap_err); end
      checks++; if (mon_multi !== 0) begin errors++; $display("FAIL m0_onehot got %0d want 0", mon_multi); end
      checks++; if (mon_mosi !== 8'hA5) begin errors++; $display("FAIL m0_mosi got %h want A5", mon_mosi); end
      checks++; if (bus.mosi !== 1'b1) begin errors++; $display("FAIL m0_mosi_hold got %b want 1", bus.mosi); end
      bus_read(2'd1, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL m0_status got %h want 01", d); end
      bus_read(2'd3, d);
      checks++; if (d !== 8'h3C) begin errors++; $display("FAIL m0_rxbuf got %h want 3C", d); end
      bus_read(2'd1, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL m0_status_clr got %h want 00", d); end
   endtask

   task automatic test_mode2();
      logic [7:0] d;
      bus_write(2'd0, 8'h89);
      repeat (2) @(negedge pro_clk);
      checks++; if (bus.sclk !== 1'b1) begin errors++; $display("FAIL m2_idle_high got %b want 1", bus.sclk); end
      run_xfer(8'h89, 8'h5A, 8'hC3);
      checks++; if (mon_low !== 34) begin errors++; $display("FAIL m2_ss_low got %0d want 34", mon_low); end
      checks++; if (mon_sel !== 8'hEF) begin errors++; $display("FAIL m2_sel got %h want EF", mon_sel); end
      checks++; if (mon_gap_err !== 0) begin errors++; $display("FAIL m2_halfper got %0d bad gaps want 0", mon_gap_err); end
      checks++; if (mon_mosi !== 8'h5A) begin errors++; $display("FAIL m2_mosi got %h want 5A", mon_mosi); end
      bus_read(2'd1, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL m2_status got %h want 01", d); end
      bus_read(2'd3, d);
      checks++; if (d !== 8'hC3) begin errors++; $display("FAIL m2_rxbuf got %h want C3", d); end
      checks++; if (bus.sclk !== 1'b1) begin errors++; $display("FAIL m2_sclk_end got %b want 1", bus.sclk); end
   endtask

   task automatic test_mode1();
      logic [7:0] d;
      run_xfer(8'hF2, 8'h96, 8'h69);
      checks++; if (mon_low !== 68) begin errors++; $display("FAIL m1_ss_low got %0d want 68", mon_low); end
      checks++; if (mon_sel !== 8'h7F) begin errors++; $display("FAIL m1_sel got %h want 7F", mon_sel); end
      checks++; if (mon_gap_err !== 0) begin errors++; $display("FAIL m1_halfper got %0d bad gaps want 0", mon_gap_err); end
      checks++; if (mon_mosi !== 8'h96) begin errors++; $display("FAIL m1_mosi got %h want 96", mon_mosi); end
      checks++; if (bus.mosi !== 1'b0) begin errors++; $display("FAIL m1_mosi_hold got %b want 0", bus.mosi); end
      bus_read(2'd3, d);
      checks++; if (d !== 8'h69) begin errors++; $display("FAIL m1_rxbuf got %h want 69", d); end
   endtask

   task automatic test_mode3();
      logic [7:0] d;
      run_xfer(8'h7C, 8'h3E, 8'hD1);
      checks++; if (mon_low !== 272) begin errors++; $display("FAIL m3_ss_low got %0d want 272", mon_low); end
      checks++; if (mon_sel !== 8'hF7) begin errors++; $display("FAIL m3_sel got %h want F7", mon_sel); end
      checks++; if (mon_idle_sclk !== 1'b1) begin errors++; $display("FAIL m3_idle got %b want 1", mon_idle_sclk); end
      checks++; if (mon_gap_err !== 0) begin errors++; $display("FAIL m3_halfper got %0d bad gaps want 0", mon_gap_err); end
      checks++; if (mon_mosi !== 8'h3E) begin errors++; $display("FAIL m3_mosi got %h want 3E", mon_mosi); end
      bus_read(2'd3, d);
      checks++; if (d !== 8'hD1) begin errors++; $display("FAIL m3_rxbuf got %h want D1", d); end
   endtask

   task automatic test_busy_writes();
      logic [7:0] d;
      set_model(8'h03, 8'h17);
      bus_write(2'd0, 8'h03);
      bus_write(2'd2, 8'hC9);
      repeat (3) @(negedge pro_clk);
      bus_write(2'd0, 8'hE0);
      bus_write(2'd2, 8'hFF);
      wait_idle();
      checks++; if (mon_mosi !== 8'hC9) begin errors++; $display("FAIL bw_mosi got %h want C9", mon_mosi); end
      checks++; if (mon_sel !== 8'hFE) begin errors++; $display("FAIL bw_sel got %h want FE", mon_sel); end
      checks++; if (mon_low !== 136) begin errors++; $display("FAIL bw_ss_low got %0d want 136", mon_low); end
      bus_read(2'd3, d);
      checks++; if (d !== 8'h17) begin errors++; $display("FAIL bw_rxbuf got %h want 17", d); end
      bus_read(2'd0, d);
      checks++; if (d !== 8'h03) begin errors++; $display("FAIL bw_ctrl got %h want 03", d); end
      bus_read(2'd2, d);
      checks++; if (d !== 8'hC9) begin errors++; $display("FAIL bw_txbuf got %h want C9", d); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      set_model(8'h00, 8'h3C);
      bus_write(2'd0, 8'h00);
      bus_write(2'd2, 8'hA5);
      repeat (5) @(negedge pro_clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.ss !== 8'hFF) begin errors++; $display("FAIL rm_ss got %h want FF", bus.ss); end
      checks++; if (bus.sclk !== 1'b0) begin errors++; $display("FAIL rm_sclk got %b want 0", bus.sclk); end
      bus_read(2'd1, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rm_status got %h want 00", d); end
      @(negedge pro_clk);
      rst = 1'b0;
      run_xfer(8'h00, 8'h81, 8'h42);
      checks++; if (mon_mosi !== 8'h81) begin errors++; $display("FAIL rm_mosi got %h want 81", mon_mosi); end
      checks++; if (mon_low !== 17) begin errors++; $display("FAIL rm_ss_low got %0d want 17", mon_low); end
      bus_read(2'd3, d);
      checks++; if (d !== 8'h42) begin errors++; $display("FAIL rm_rxbuf got %h want 42", d); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      run_xfer(8'h00, 8'h18, 8'hA0);
      set_model(8'h00, 8'hE7);
      bus_write(2'd2, 8'h7E);
      bus_read(2'd1, d);
      checks++; if (d !== 8'h02) begin errors++; $display("FAIL bb_status_busy got %h want 02", d); end
      wait_idle();
      checks++; if (mon_mosi !== 8'h7E) begin errors++; $display("FAIL bb_mosi got %h want 7E", mon_mosi); end
      bus_read(2'd3, d);
      checks++; if (d !== 8'hE7) begin errors++; $display("FAIL bb_rxbuf got %h want E7", d); end
   endtask

   initial begin
      bus.CS = 1'b0; bus.WR = 1'b0; bus.RD = 1'b0; bus.addr = 2'd0;
      repeat (3) @(negedge pro_clk);
      rst = 1'b0;
      test_reset();
      test_mode0();
      test_mode2();
      test_mode1();
      test_mode3();
      test_busy_writes();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/spi_master.md
# spi_master

Processor-bus-mapped SPI master. It sits between an 8-bit host bus (chip select, 2-bit address, WR/RD strobes, tri-state data bus) and up to eight SPI slaves. A 4-register map configures it: slave select, CPOL/CPHA mode and clock rate. Each write to the transmit buffer starts one 8-bit, MSB-first, full-duplex transfer. Completion is flagged in a status register that the host polls.

## Interface
- No parameters.
- pro_clk  in  1  system clock; all registers sample on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- miso  in  1  serial data from the selected slave.
- mosi  out  1  serial data to the slaves.
- sclk  out  1  SPI clock; idles at CPOL.
- ss  out  8  active-low slave selects; at most one low at a time.
- data_bus  inout  8  host data bus; driven only when CS&RD, else high-Z.
- CS  in  1  block select, active-high.
- addr  in  2  register address.
- WR  in  1  write strobe, active-high, qualified by CS.
- RD  in  1  read strobe, active-high, qualified by CS.
- One clock; reset is asynchronous and active-high.

## Operation
- Register map:
  - addr 0: CTRL, read/write. [7:5] slave index, [4] CPHA, [3] CPOL, [2:0] DIV.
  - addr 1: STATUS, read-only. {6'b0, busy, done}.
  - addr 2: TXBUF, read/write. A write starts a transfer.
  - addr 3: RXBUF, read-only. Reading it clears done.
- Writes: the register is updated on the pro_clk rising edge with CS&WR=1.
  - Writes to CTRL or TXBUF while busy=1 are ignored.
  - Writes to addresses 1 and 3 are ignored.
- Reads: data_bus is driven combinationally with the addressed register while CS&RD=1.
- Half-period H = 2^DIV pro_clk cycles. DIV=0 gives sclk = pro_clk/2; DIV=7 gives pro_clk/256.
- States: IDLE → ASSERT → SHIFT → RELEASE → IDLE.
  - IDLE: ss=8'hFF, sclk=CPOL.
  - A TXBUF write loads the shift register, sets busy, clears done, and enters ASSERT.
  - ASSERT: ss[CTRL[7:5]] goes low.
  - SHIFT runs 16 sclk edges, one every H cycles. The first edge comes H after ss falls.
  - CPHA=0:
    - mosi = bit7 when ss falls.
    - Leading edges (odd) sample miso.
    - Trailing edges (even) shift out the next bit.
  - CPHA=1:
    - Leading edges drive the next bit (bit7 first).
    - Trailing edges sample miso.
  - Leading edge = sclk leaving CPOL.
  - RELEASE: H cycles after the 16th edge, ss returns to FFh. In the same cycle RXBUF is loaded with the 8 sampled bits (MSB first), busy=0, done=1.
- Total ss-low time is 17·H cycles for every mode.
- CTRL is latched at transfer start. sclk idle level follows CTRL[3] while idle.
- mosi holds its last value after a transfer.
- Simultaneous done-set and RXBUF read: set wins.
- Reset mid-transfer aborts it immediately: ss=FFh, sclk=0, busy=0, no RXBUF update.

## Timing
- Reset values:
  - CTRL=00h, TXBUF=00h, RXBUF=00h, done=0, busy=0.
  - ss=FFh, sclk=0, mosi=0, data_bus=Z.
- ss asserts on the first rising edge after the TXBUF write edge.
- Read latency is 0 cycles (combinational from CS/RD/addr).
- done and busy are visible in STATUS on the cycle after ss deasserts.
- sclk, mosi and ss are registered outputs, glitch-free.

## Test plan
1. CTRL=00h, TXBUF=A5h, slave returns 3Ch:
   - ss[0] low for 17 cycles; sclk = pro_clk/2 idling low; mosi sampled on rising edges = A5h.
   - STATUS reads 01h; RXBUF reads 3Ch; a subsequent STATUS read gives 00h.
2. CTRL=89h (ss[4], CPOL=1, CPHA=0, DIV=1), TXBUF=5Ah:
   - sclk idles high, period 4 cycles; mosi valid on falling edges = 5Ah.
   - MISO sampled on falling edges into RXBUF; done=1 after ss[4] rises.
3. CTRL=F2h (ss[7], CPOL=0, CPHA=1, DIV=2):
   - Data changes on rising edges, sampled on falling edges; sclk period 8 cycles.
   - ss[7] low for 68 cycles.
4. CTRL=7Ch (ss[3], CPOL=1, CPHA=1, DIV=4):
   - Data changes on falling edges, sampled on rising edges; period 32 cycles.
   - MOSI and MISO bytes both verified.
5. TXBUF write and CTRL write during busy:
   - Both ignored; transfer completes with the original data and slave select.
6. Assert rst mid-transfer (test 1):
   - ss=FFh, sclk=0, STATUS=00h immediately.
   - A new TXBUF write then transfers correctly.
